sr_raster_reorder: RTL and testbench

// - Sits directly downstream of the 2x super-resolution stage. Accepts one 2x2 high-res block
//   per transfer: TL, TR, BL, BR.
// - Emits the blocks in raster order, two pixels per transfer:
//   - top row of a low-res line passes straight through;
//   - bottom row is parked in a line buffer and replayed afterwards.
// - Feeds the 4K output/VDMA writer. Output rate is 2 px/transfer, so input runs at half rate.

---
 rtl/sr_raster_reorder_pkg.sv | 21 ++
 rtl/sr_raster_reorder_if.sv | 24 ++
 rtl/sr_raster_reorder_line_buf.sv | 26 ++
 rtl/sr_raster_reorder.sv | 128 ++++++++++++
 tb/tb_sr_raster_reorder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_raster_reorder_pkg.sv
// Shared definitions for the super-resolution raster reorder block:
// FSM state encodings, lane positions inside a 2x2 input block, width helper.
package sr_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PRIME = 2'd1,
        ST_DRAIN = 2'd2
    } sr_state_e;

    // Lane index of each pixel inside the packed {TL,TR,BL,BR} input word
    localparam int LANE_TL = 3;
    localparam int LANE_TR = 2;
    localparam int LANE_BL = 1;
    localparam int LANE_BR = 0;

    function automatic int clog2_safe(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sr_raster_reorder_if.sv
// Stream bundle between the SR stage, the reorder block and the output writer.
// master = upstream/downstream environment, slave = the reorder block.
interface sr_raster_reorder_if #(
    parameter int PW = 24
);
    logic [4*PW-1:0] pixel_in;
    logic            pin_en;
    logic            busy;
    logic [2*PW-1:0] pixel_out;
    logic            pout_en;
    logic            pout_sof;
    logic            pout_eol;
    logic            stuck;

    modport master (
        output pixel_in, pin_en, stuck,
        input  busy, pixel_out, pout_en, pout_sof, pout_eol
    );

    modport slave (
        input  pixel_in, pin_en, stuck,
        output busy, pixel_out, pout_en, pout_sof, pout_eol
    );
endinterface

// File: rtl/sr_raster_reorder_line_buf.sv
// Simple dual-port line buffer holding the bottom pixel pair of each block.
// Read data is registered and holds while the read enable is low.
module sr_line_buf #(
    parameter int DEPTH = 1920,
    parameter int DW    = 48,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // No reset on the array or read register so the memory maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sr_raster_reorder.sv
// Reorders 2x2 SR blocks into raster order, two pixels per output transfer:
// top pairs pass straight through, bottom pairs are parked and replayed after the line.
module sr_raster_reorder
    import sr_pkg::*;
#(
    parameter int PIXEL_WIDTH = 24,
    parameter int IN_WIDTH    = 1920,
    parameter int IN_HEIGHT   = 1080
) (
    input  logic                clk,
    input  logic                rst_n,
    sr_raster_reorder_if.slave  bus
);
    localparam int PW = PIXEL_WIDTH;
    localparam int CW = clog2_safe(IN_WIDTH);
    localparam int RW = clog2_safe(IN_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    sr_state_e         r_state;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [2*PW-1:0]   r_pix;
    logic              r_en;
    logic              r_sof;
    logic              r_eol;

    logic              w_out_adv;
    logic              w_busy;
    logic              w_in_xfer;
    logic              w_col_last;
    logic              w_re;
    logic [CW-1:0]     w_raddr;
    logic [2*PW-1:0]   w_top;
    logic [2*PW-1:0]   w_bot;
    logic [2*PW-1:0]   w_rdata;

    // Output register may take new data when it is empty or being consumed
    assign w_out_adv  = ~r_en | ~bus.stuck;
    assign w_busy     = (r_state == ST_FILL) ? (r_en & bus.stuck) : 1'b1;
    assign w_in_xfer  = bus.pin_en & ~w_busy;
    assign w_col_last = (r_col == COL_LAST);

    assign w_top = {bus.pixel_in[LANE_TL*PW +: PW], bus.pixel_in[LANE_TR*PW +: PW]};
    assign w_bot = {bus.pixel_in[LANE_BL*PW +: PW], bus.pixel_in[LANE_BR*PW +: PW]};

    // Read one pair ahead: PRIME fetches addr 0, each DRAIN advance fetches the next column
    assign w_re    = (r_state == ST_PRIME) | ((r_state == ST_DRAIN) & w_out_adv);
    assign w_raddr = ((r_state == ST_DRAIN) && !w_col_last) ? r_col + 1'b1 : '0;

    sr_line_buf #(
        .DEPTH (IN_WIDTH),
        .DW    (2*PW),
        .AW    (CW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_in_xfer),
        .i_waddr (r_col),
        .i_wdata (w_bot),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_col   <= '0;
            r_row   <= '0;
            r_pix   <= '0;
            r_en    <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_in_xfer) begin
                        r_pix <= w_top;
                        r_en  <= 1'b1;
                        r_sof <= (r_col == '0) && (r_row == '0);
                        r_eol <= w_col_last;
                        if (w_col_last) begin
                            r_col   <= '0;
                            r_state <= ST_PRIME;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else if (w_out_adv) begin
                        r_en  <= 1'b0;
                        r_sof <= 1'b0;
                        r_eol <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    // Last top pair may still be stalled; leave it alone until it goes
                    if (w_out_adv) begin
                        r_en    <= 1'b0;
                        r_sof   <= 1'b0;
                        r_eol   <= 1'b0;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_adv) begin
                        r_pix <= w_rdata;
                        r_en  <= 1'b1;
                        r_sof <= 1'b0;
                        r_eol <= w_col_last;
                        if (w_col_last) begin
                            r_col   <= '0;
                            r_row   <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                            r_state <= ST_FILL;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.pixel_out = r_pix;
    assign bus.pout_en   = r_en;
    assign bus.pout_sof  = r_sof;
    assign bus.pout_eol  = r_eol;
endmodule

// File: tb/tb_sr_raster_reorder.sv
// Scoreboard bench for sr_raster_reorder: a 4x2 instance for the main tests and a
// 1-wide instance for the single-block line case.
module tb_sr_raster_reorder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_raster_reorder_if #(.PW(8)) ifa ();
    sr_raster_reorder_if #(.PW(8)) ifb ();

    sr_raster_reorder #(.PIXEL_WIDTH(8), .IN_WIDTH(4), .IN_HEIGHT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    sr_raster_reorder #(.PIXEL_WIDTH(8), .IN_WIDTH(1), .IN_HEIGHT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    typedef struct packed {
        logic [15:0] pix;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   pair_cnt = 0;
    int   sof_cnt = 0;
    bit   rs_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] blk(input logic [7:0] base, input int k);
        logic [7:0] b;
        b = base + 8'(4 * k);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic push(input bit sel, input logic [15:0] p, input logic s, input logic e);
        exp_t x;
        x.pix = p; x.sof = s; x.eol = e;
        if (sel) qb.push_back(x);
        else     qa.push_back(x);
    endtask

    // Hand-computed raster order for blocks blk(0,0..3) on a row-0 line
    task automatic push_l0();
        push(0, 16'h0302, 1, 0); push(0, 16'h0706, 0, 0);
        push(0, 16'h0B0A, 0, 0); push(0, 16'h0F0E, 0, 1);
        push(0, 16'h0100, 0, 0); push(0, 16'h0504, 0, 0);
        push(0, 16'h0908, 0, 0); push(0, 16'h0D0C, 0, 1);
    endtask

    task automatic push_line(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3, input logic sof);
        logic [31:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < 4; i++) push(0, b[i][31:16], sof && (i == 0), i == 3);
        for (int i = 0; i < 4; i++) push(0, b[i][15:0], 1'b0, i == 3);
    endtask

    task automatic drive(input bit sel, input logic [31:0] d, input logic en);
        if (sel) begin ifb.pixel_in = d; ifb.pin_en = en; end
        else     begin ifa.pixel_in = d; ifa.pin_en = en; end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the capturing edge
    task automatic send(input bit sel, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        drive(sel, d, 1'b1);
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = sel ? !ifb.busy : !ifa.busy;
            @(posedge clk); #1;
        end
        drive(sel, d, 1'b0);
        check(sel ? "b_accept_timeout" : "a_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_empty(input bit sel);
        for (int t = 0; t < 400; t++) begin
            if ((sel ? qb.size() : qa.size()) == 0) break;
            @(posedge clk);
        end
        check(sel ? "b_drain_timeout" : "a_drain_timeout",
              64'(sel ? qb.size() : qa.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic mon(input bit sel);
        logic [15:0] pix;
        logic        en, sof, eol, stk, bsy;
        logic [18:0] prev;
        bit          st;
        string       p;
        exp_t        e;
        st   = 1'b0;
        prev = '0;
        p    = sel ? "b_" : "a_";
        forever begin
            @(negedge clk);
            pix = sel ? ifb.pixel_out : ifa.pixel_out;
            en  = sel ? ifb.pout_en   : ifa.pout_en;
            sof = sel ? ifb.pout_sof  : ifa.pout_sof;
            eol = sel ? ifb.pout_eol  : ifa.pout_eol;
            stk = sel ? ifb.stuck     : ifa.stuck;
            bsy = sel ? ifb.busy      : ifa.busy;
            if (!rst_n) begin
                st = 1'b0;
                continue;
            end
            if (st) check({p, "hold_while_stuck"}, {pix, en, sof, eol}, prev);
            if (en && stk) check({p, "busy_on_stall"}, bsy, 1'b1);
            if (en && !stk) begin
                if ((sel ? qb.size() : qa.size()) == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL %sunexpected_pair got=%h sof=%b eol=%b required=none at %0t",
                             p, pix, sof, eol, $time);
                end else begin
                    e = sel ? qb.pop_front() : qa.pop_front();
                    check({p, "pixel_out"}, pix, e.pix);
                    check({p, "pout_sof"}, sof, e.sof);
                    check({p, "pout_eol"}, eol, e.eol);
                end
                if (!sel) begin
                    pair_cnt++;
                    if (sof) sof_cnt++;
                end
            end
            st   = en && stk;
            prev = {pix, en, sof, eol};
        end
    endtask

    task automatic stuck_gen();
        forever begin
            @(posedge clk); #1;
            ifa.stuck = rs_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    initial begin
        int cnt;
        int acc;
        ifa.pixel_in = '0; ifa.pin_en = 1'b0; ifa.stuck = 1'b0;
        ifb.pixel_in = '0; ifb.pin_en = 1'b0; ifb.stuck = 1'b0;
        fork
            mon(1'b0);
            mon(1'b1);
            stuck_gen();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pout_en",   ifa.pout_en,   1'b0);
        check("rst_pout_sof",  ifa.pout_sof,  1'b0);
        check("rst_pout_eol",  ifa.pout_eol,  1'b0);
        check("rst_pixel_out", ifa.pixel_out, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy_after_release", ifa.busy, 1'b0);

        // Test 1: one row-0 line, then busy for PRIME + 4 DRAIN cycles
        push_l0();
        for (int k = 0; k < 4; k++) send(0, blk(8'h00, k));
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (ifa.busy) cnt++;
            @(posedge clk); #1;
        end
        check("t1_busy_cycles", 64'(cnt), 64'd5);
        wait_empty(0);

        // Test 4: row-1 line, then pin_en held high with changing data through DRAIN
        push_line(blk(8'h10, 0), blk(8'h10, 1), blk(8'h10, 2), blk(8'h10, 3), 1'b0);
        push_line(32'hA6B6C6D6, blk(8'h20, 1), blk(8'h20, 2), blk(8'h20, 3), 1'b1);
        for (int k = 0; k < 4; k++) send(0, blk(8'h10, k));
        acc = 0;
        for (int n = 1; n <= 20 && acc == 0; n++) begin
            drive(0, {8'hA0 + 8'(n), 8'hB0 + 8'(n), 8'hC0 + 8'(n), 8'hD0 + 8'(n)}, 1'b1);
            @(negedge clk);
            if (!ifa.busy) acc = n;
            @(posedge clk); #1;
        end
        drive(0, '0, 1'b0);
        check("t4_first_accept_after_drain", 64'(acc), 64'd6);
        for (int k = 1; k < 4; k++) send(0, blk(8'h20, k));

        // Test 2: finish frame 2; two frames give two sofs and 32 pairs
        push_line(blk(8'h30, 0), blk(8'h30, 1), blk(8'h30, 2), blk(8'h30, 3), 1'b0);
        for (int k = 0; k < 4; k++) send(0, blk(8'h30, k));
        wait_empty(0);
        check("t2_sof_count",  64'(sof_cnt),  64'd2);
        check("t2_pair_count", 64'(pair_cnt), 64'd32);

        // Test 3: random downstream stall, row wrapped back to 0
        rs_en = 1'b1;
        push_l0();
        for (int k = 0; k < 4; k++) send(0, blk(8'h00, k));
        wait_empty(0);
        rs_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Test 5: reset after two blocks of a row-1 line
        push(0, 16'h4342, 1'b0, 1'b0);
        send(0, blk(8'h40, 0));
        send(0, blk(8'h40, 1));
        check("t5_pre_reset_pout_en", ifa.pout_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_pout_en",   ifa.pout_en,   1'b0);
        check("t5_rst_pout_sof",  ifa.pout_sof,  1'b0);
        check("t5_rst_pout_eol",  ifa.pout_eol,  1'b0);
        check("t5_rst_pixel_out", ifa.pixel_out, 16'h0000);
        check("t5_queue_empty",   64'(qa.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_l0();
        for (int k = 0; k < 4; k++) send(0, blk(8'h00, k));
        wait_empty(0);

        // Test 6: one-block lines
        push(1, 16'hAABB, 1'b1, 1'b1);
        push(1, 16'hCCDD, 1'b0, 1'b1);
        send(1, 32'hAABBCCDD);
        wait_empty(1);
        @(negedge clk);
        check("t6_busy_back_in_fill", ifb.busy, 1'b0);
        @(posedge clk); #1;
        push(1, 16'h1122, 1'b0, 1'b1);
        push(1, 16'h3344, 1'b0, 1'b1);
        send(1, 32'h11223344);
        wait_empty(1);
        push(1, 16'h5566, 1'b1, 1'b1);
        push(1, 16'h7788, 1'b0, 1'b1);
        send(1, 32'h55667788);
        wait_empty(1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
